hazard_flush_ctrl: RTL and testbench
====================================

// Module: hazard_flush_ctrl
// PURPOSE
//  Pipeline control for the 16-bit count-up CPU. Drives the IF/ID instruction
//  register: load enable and Bjudge/NOP-inject flush (NOP = 16'h001F). Drives
//  the PC mux and the ID/EX bubble.
//  Redirects fetch on a taken branch, flushes wrong-path slots for FLUSH_CYCLES.
//  Stalls one cycle on a load-use hazard. Keeps saturating flush/stall event counters.
// PARAMETERS
//  REG_AW        3        register-address width
//  FLUSH_CYCLES  2        IF/ID slots squashed per taken branch (1..7)
//  CNT_W         16       width of event counters
// PORTS
//  CLK          in   1      clock, rising edge
//  RSTN         in   1      reset, synchronous, active-low
//  br_taken     in   1      EX stage resolved a taken branch this cycle
//  ex_mem_read  in   1      instruction in EX is a load
//  ex_rd        in   REG_AW load destination register in EX
//  id_rs_a      in   REG_AW ID source register A
//  id_rs_b      in   REG_AW ID source register B
//  id_uses_a    in   1      ID instruction reads rs_a
//  id_uses_b    in   1      ID instruction reads rs_b
//  pc_load      out  1      PC register load enable
//  pc_sel       out  1      1 = PC takes branch target, 0 = PC+1
//  if_id_load   out  1      IF/ID register load enable
//  if_id_flush  out  1      to IF/ID Bjudge: write NOP, overrides load
//  id_ex_flush  out  1      ID/EX loads a bubble (NOP) instead of ID output
//  busy         out  1      state != RUN
//  flush_cnt    out  CNT_W  taken-branch events, saturating
//  stall_cnt    out  CNT_W  load-use stall events, saturating
// BEHAVIOUR
//  Reset:
//  - While RSTN=0 at a rising edge: state<=RUN, remain<=0, counters<=0.
//  - Combinational outputs are forced during reset: pc_load=0, pc_sel=0,
//    if_id_load=0, if_id_flush=1, id_ex_flush=1, busy=0.
//  - Reset mid-FLUSH or mid-STALL abandons the operation; no residual flush.
//  Hazard:
//  - hz = ex_mem_read & ((id_uses_a & ex_rd==id_rs_a) | (id_uses_b & ex_rd==id_rs_b)).
//  - Register 0 is not special-cased.
//  Outputs are Mealy (same-cycle) from state and inputs. Priority: reset > br_taken > hz.
//  RUN:
//  - br_taken: pc_load=1, pc_sel=1, if_id_flush=1, id_ex_flush=1.
//    Next state FLUSH with remain=FLUSH_CYCLES-1; if FLUSH_CYCLES==1, stay RUN.
//  - hz and !br_taken: pc_load=0, if_id_load=0, id_ex_flush=1. Next state STALL.
//  - else: pc_load=1, pc_sel=0, if_id_load=1, flushes=0.
//  FLUSH:
//  - pc_load=1, pc_sel=0, if_id_flush=1, id_ex_flush=1.
//  - remain decrements; go to RUN when remain==1 at the edge.
//  - Total flushed IF/ID slots per branch = FLUSH_CYCLES.
//  - br_taken in FLUSH restarts the sequence exactly as in RUN. The new redirect wins.
//  - hz is ignored in FLUSH.
//  STALL:
//  - Lasts exactly one cycle. Outputs match RUN-no-hazard: the bubble already sits in EX.
//  - hz is not re-evaluated in STALL.
//  - br_taken in STALL is handled as in RUN and goes to FLUSH.
//  Counters:
//  - flush_cnt +1 on each cycle br_taken is acted on.
//  - stall_cnt +1 on each RUN->STALL transition.
//  - Both hold at 2^CNT_W-1 and never wrap.
//  - Both update at the same edge as the state change.
//  Invariants:
//  - if_id_flush=1 implies if_id_load is don't-care; it is driven 0.
//  - pc_sel=1 only together with pc_load=1.
// STRUCTURE
//  Shared header pipe_ctrl_defs.vh:
//  - NOP_INSTR = 16'h001F
//  - state encodings ST_RUN=2'd0, ST_FLUSH=2'd1, ST_STALL=2'd2
//  - The IR register and the decoder share the same NOP constant.
//  Sub-module sat_counter (parameter W): inc, sync active-low clear, saturating.
//  - Instantiated twice, once per event counter.
//  The FSM, remain counter and hazard compare live in this module.
// TESTING
//  1 Hold RSTN=0 3 cycles, then release.
//    -> if_id_flush=1 and pc_load=0 during reset; after release RUN, pc_load=1, counters=0.
//  2 br_taken pulse 1 cycle, FLUSH_CYCLES=2.
//    -> if_id_flush=1 for 2 consecutive cycles, pc_sel=1 only in the first, busy=1 in the second.
//    -> flush_cnt=1.
//  3 ex_mem_read=1, ex_rd=3, id_rs_b=3, id_uses_b=1.
//    -> one cycle pc_load=0, if_id_load=0, id_ex_flush=1, then normal; stall_cnt=1.
//  4 Hazard and br_taken in the same cycle.
//    -> branch path taken, no stall, stall_cnt=0, flush_cnt=1.
//  5 br_taken again in the 2nd FLUSH cycle.
//    -> pc_sel=1 that cycle; flush extends 2 more cycles (3 total if_id_flush).
//  6 Force flush_cnt to 16'hFFFE and apply 3 branches.
//    -> saturates at 16'hFFFF.
//  7 Assert RSTN=0 in the first FLUSH cycle.
//    -> after release, state RUN, no further if_id_flush.

Source files
------------

// File: rtl/hazard_flush_ctrl_pkg.sv
// Shared constants and state encoding for the pipeline hazard/flush controller.
// The IR register and the decoder both take the NOP encoding from here.
package hazard_flush_ctrl_pkg;

  localparam logic [15:0] NOP_INSTR = 16'h001F;
  localparam int          REM_W     = 3;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_STALL = 2'd2
  } state_t;

endpackage

// File: rtl/hazard_flush_ctrl_sat_counter.sv
// Saturating event counter: synchronous active-low clear, +1 per inc pulse,
// holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         i_clr_n,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge CLK) begin
    if (!i_clr_n) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_flush_ctrl.sv
// IF/ID / PC / ID-EX control for the 16-bit count-up CPU: branch redirect with
// wrong-path squash, one-cycle load-use stall, saturating event counters.
module hazard_flush_ctrl
  import hazard_flush_ctrl_pkg::*;
#(
  parameter int REG_AW       = 3,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              br_taken,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [REG_AW-1:0] id_rs_a,
  input  logic [REG_AW-1:0] id_rs_b,
  input  logic              id_uses_a,
  input  logic              id_uses_b,
  output logic              pc_load,
  output logic              pc_sel,
  output logic              if_id_load,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              busy,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [1:0]        dbg_state
);

  // Handshake-free control: every output is a same-cycle (Mealy) function of
  // the registered state and the current inputs; consumers act on it at the
  // next rising edge. Priority is reset > br_taken > load-use hazard.

  localparam logic [REM_W-1:0] REM_INIT = REM_W'(FLUSH_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [REM_W-1:0] r_remain;
  logic [REM_W-1:0] w_remain_nxt;
  logic             w_hz;
  logic             w_flush_ev;
  logic             w_stall_ev;

  // Register 0 is compared like any other register.
  assign w_hz = ex_mem_read &
                ((id_uses_a & (ex_rd == id_rs_a)) |
                 (id_uses_b & (ex_rd == id_rs_b)));

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_state  <= ST_RUN;
      r_remain <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_remain <= w_remain_nxt;
    end
  end

  always_comb begin
    pc_load      = 1'b0;
    pc_sel       = 1'b0;
    if_id_load   = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    busy         = 1'b0;
    w_state_nxt  = r_state;
    w_remain_nxt = r_remain;
    w_flush_ev   = 1'b0;
    w_stall_ev   = 1'b0;

    if (!RSTN) begin
      // Hold the pipe in NOPs while reset is asserted.
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      w_state_nxt  = ST_RUN;
      w_remain_nxt = '0;
    end else begin
      busy = (r_state != ST_RUN);
      if (br_taken) begin
        // A redirect in any state restarts the squash window.
        pc_load      = 1'b1;
        pc_sel       = 1'b1;
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        w_flush_ev   = 1'b1;
        w_remain_nxt = REM_INIT;
        w_state_nxt  = (FLUSH_CYCLES == 1) ? ST_RUN : ST_FLUSH;
      end else begin
        unique case (r_state)
          ST_RUN: begin
            if (w_hz) begin
              id_ex_flush = 1'b1;
              w_stall_ev  = 1'b1;
              w_state_nxt = ST_STALL;
            end else begin
              pc_load    = 1'b1;
              if_id_load = 1'b1;
            end
          end
          ST_FLUSH: begin
            pc_load      = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            w_remain_nxt = r_remain - 1'b1;
            if (r_remain == REM_W'(1)) begin
              w_state_nxt = ST_RUN;
            end
          end
          ST_STALL: begin
            // The bubble is already in EX, so the pipe simply advances.
            pc_load     = 1'b1;
            if_id_load  = 1'b1;
            w_state_nxt = ST_RUN;
          end
          default: begin
            w_state_nxt  = ST_RUN;
            w_remain_nxt = '0;
          end
        endcase
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .CLK     (CLK),
    .i_clr_n (RSTN),
    .i_inc   (w_flush_ev),
    .o_cnt   (flush_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK     (CLK),
    .i_clr_n (RSTN),
    .i_inc   (w_stall_ev),
    .o_cnt   (stall_cnt)
  );

  assign dbg_state = r_state;

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Directed bench for hazard_flush_ctrl; a second narrow-counter instance
// exercises counter saturation in a few cycles.
module tb_hazard_flush_ctrl;

  logic       CLK;
  logic       RSTN;
  logic       br_taken;
  logic       ex_mem_read;
  logic [2:0] ex_rd;
  logic [2:0] id_rs_a;
  logic [2:0] id_rs_b;
  logic       id_uses_a;
  logic       id_uses_b;

  logic        pc_load, pc_sel, if_id_load, if_id_flush, id_ex_flush, busy;
  logic [15:0] flush_cnt, stall_cnt;
  logic [1:0]  dbg_state;

  logic        s_pc_load, s_pc_sel, s_if_id_load, s_if_id_flush, s_id_ex_flush, s_busy;
  logic [1:0]  s_flush_cnt, s_stall_cnt;
  logic [1:0]  s_dbg_state;

  int n_cmp;
  int n_err;

  // {pc_load, pc_sel, if_id_load, if_id_flush, id_ex_flush, busy}
  logic [5:0] outs;
  assign outs = {pc_load, pc_sel, if_id_load, if_id_flush, id_ex_flush, busy};

  localparam logic [5:0] O_RESET  = 6'b000110;
  localparam logic [5:0] O_NORMAL = 6'b101000;
  localparam logic [5:0] O_BR_RUN = 6'b110110;
  localparam logic [5:0] O_BR_BSY = 6'b110111;
  localparam logic [5:0] O_FLUSH  = 6'b100111;
  localparam logic [5:0] O_HZ     = 6'b000010;
  localparam logic [5:0] O_STALL  = 6'b101001;

  hazard_flush_ctrl #(.REG_AW(3), .FLUSH_CYCLES(2), .CNT_W(16)) u_dut (
    .CLK(CLK), .RSTN(RSTN), .br_taken(br_taken), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .id_rs_a(id_rs_a), .id_rs_b(id_rs_b),
    .id_uses_a(id_uses_a), .id_uses_b(id_uses_b),
    .pc_load(pc_load), .pc_sel(pc_sel), .if_id_load(if_id_load),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .busy(busy),
    .flush_cnt(flush_cnt), .stall_cnt(stall_cnt), .dbg_state(dbg_state)
  );

  hazard_flush_ctrl #(.REG_AW(3), .FLUSH_CYCLES(2), .CNT_W(2)) u_sat (
    .CLK(CLK), .RSTN(RSTN), .br_taken(br_taken), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .id_rs_a(id_rs_a), .id_rs_b(id_rs_b),
    .id_uses_a(id_uses_a), .id_uses_b(id_uses_b),
    .pc_load(s_pc_load), .pc_sel(s_pc_sel), .if_id_load(s_if_id_load),
    .if_id_flush(s_if_id_flush), .id_ex_flush(s_id_ex_flush), .busy(s_busy),
    .flush_cnt(s_flush_cnt), .stall_cnt(s_stall_cnt), .dbg_state(s_dbg_state)
  );

  // Clock / reset block
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Driver tasks
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    br_taken    = 1'b0;
    ex_mem_read = 1'b0;
    ex_rd       = 3'd0;
    id_rs_a     = 3'd0;
    id_rs_b     = 3'd0;
    id_uses_a   = 1'b0;
    id_uses_b   = 1'b0;
  endtask

  task automatic apply_reset();
    RSTN = 1'b0;
    idle_inputs();
    cyc();
    RSTN = 1'b1;
    #2;
  endtask

  task automatic test_reset();
    RSTN = 1'b0;
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      #2;
      n_cmp++;
      if (outs !== O_RESET) begin
        n_err++;
        $display("FAIL reset_outs cyc%0d: got %b want %b", i, outs, O_RESET);
      end
      cyc();
    end
    n_cmp++;
    if (dbg_state !== 2'd0 || flush_cnt !== 16'd0 || stall_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL reset_regs: state=%0d fc=%0d sc=%0d want 0/0/0", dbg_state, flush_cnt, stall_cnt);
    end
    RSTN = 1'b1;
    #2;
    n_cmp++;
    if (outs !== O_NORMAL) begin
      n_err++;
      $display("FAIL reset_release: got %b want %b", outs, O_NORMAL);
    end
  endtask

  task automatic test_branch();
    br_taken = 1'b1;
    #2;
    n_cmp++;
    if (outs !== O_BR_RUN) begin
      n_err++;
      $display("FAIL branch_c0: got %b want %b", outs, O_BR_RUN);
    end
    cyc();
    br_taken = 1'b0;
    #2;
    n_cmp++;
    if (outs !== O_FLUSH || dbg_state !== 2'd1) begin
      n_err++;
      $display("FAIL branch_c1: got %b st=%0d want %b st=1", outs, dbg_state, O_FLUSH);
    end
    n_cmp++;
    if (flush_cnt !== 16'd1) begin
      n_err++;
      $display("FAIL branch_cnt: got %0d want 1", flush_cnt);
    end
    cyc();
    #2;
    n_cmp++;
    if (outs !== O_NORMAL || dbg_state !== 2'd0) begin
      n_err++;
      $display("FAIL branch_c2: got %b st=%0d want %b st=0", outs, dbg_state, O_NORMAL);
    end
  endtask

  task automatic test_stall();
    // Matching register but B not used: no hazard
    ex_mem_read = 1'b1; ex_rd = 3'd3; id_rs_b = 3'd3; id_uses_b = 1'b0;
    id_rs_a = 3'd5; id_uses_a = 1'b1;
    #2;
    n_cmp++;
    if (outs !== O_NORMAL) begin
      n_err++;
      $display("FAIL stall_unused_b: got %b want %b", outs, O_NORMAL);
    end
    // Match on A but not a load: no hazard
    ex_mem_read = 1'b0; id_rs_a = 3'd3;
    #1;
    n_cmp++;
    if (outs !== O_NORMAL) begin
      n_err++;
      $display("FAIL stall_not_load: got %b want %b", outs, O_NORMAL);
    end
    ex_mem_read = 1'b1; id_rs_a = 3'd0; id_uses_a = 1'b0; id_uses_b = 1'b1;
    #1;
    n_cmp++;
    if (outs !== O_HZ) begin
      n_err++;
      $display("FAIL stall_c0: got %b want %b", outs, O_HZ);
    end
    cyc();
    #2;
    n_cmp++;
    if (outs !== O_STALL || dbg_state !== 2'd2) begin
      n_err++;
      $display("FAIL stall_c1: got %b st=%0d want %b st=2", outs, dbg_state, O_STALL);
    end
    n_cmp++;
    if (stall_cnt !== 16'd1) begin
      n_err++;
      $display("FAIL stall_cnt: got %0d want 1", stall_cnt);
    end
    idle_inputs();
    cyc();
    #2;
    n_cmp++;
    if (outs !== O_NORMAL || stall_cnt !== 16'd1) begin
      n_err++;
      $display("FAIL stall_c2: got %b sc=%0d want %b sc=1", outs, stall_cnt, O_NORMAL);
    end
  endtask

  task automatic test_hz_and_branch();
    apply_reset();
    ex_mem_read = 1'b1; ex_rd = 3'd0; id_rs_a = 3'd0; id_uses_a = 1'b1;
    br_taken = 1'b1;
    #1;
    n_cmp++;
    if (outs !== O_BR_RUN) begin
      n_err++;
      $display("FAIL hzbr_c0: got %b want %b", outs, O_BR_RUN);
    end
    cyc();
    br_taken = 1'b0;
    #2;
    n_cmp++;
    if (outs !== O_FLUSH) begin
      n_err++;
      $display("FAIL hzbr_flush_ignores_hz: got %b want %b", outs, O_FLUSH);
    end
    idle_inputs();
    cyc();
    #2;
    n_cmp++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd1 || outs !== O_NORMAL) begin
      n_err++;
      $display("FAIL hzbr_end: sc=%0d fc=%0d outs=%b want 0/1/%b", stall_cnt, flush_cnt, outs, O_NORMAL);
    end
  endtask

  task automatic test_back_to_back();
    int n_iff;
    n_iff = 0;
    br_taken = 1'b1;
    #2;
    n_cmp++;
    if (outs !== O_BR_RUN) begin
      n_err++;
      $display("FAIL b2b_c0: got %b want %b", outs, O_BR_RUN);
    end
    n_iff += int'(if_id_flush);
    cyc();
    #2;
    n_cmp++;
    if (outs !== O_BR_BSY) begin
      n_err++;
      $display("FAIL b2b_c1: got %b want %b", outs, O_BR_BSY);
    end
    n_iff += int'(if_id_flush);
    cyc();
    br_taken = 1'b0;
    #2;
    n_cmp++;
    if (outs !== O_FLUSH) begin
      n_err++;
      $display("FAIL b2b_c2: got %b want %b", outs, O_FLUSH);
    end
    n_iff += int'(if_id_flush);
    cyc();
    #2;
    n_iff += int'(if_id_flush);
    n_cmp++;
    if (n_iff != 3 || flush_cnt !== 16'd3) begin
      n_err++;
      $display("FAIL b2b_total: flushes=%0d fc=%0d want 3/3", n_iff, flush_cnt);
    end
  endtask

  task automatic test_saturation();
    logic [1:0]  exp_sat;
    logic [15:0] exp_main;
    apply_reset();
    br_taken = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      exp_sat  = (k > 3) ? 2'd3 : 2'(k);
      exp_main = 16'(k);
      n_cmp++;
      if (s_flush_cnt !== exp_sat || flush_cnt !== exp_main) begin
        n_err++;
        $display("FAIL sat_k%0d: narrow=%0d wide=%0d want %0d/%0d", k, s_flush_cnt, flush_cnt, exp_sat, exp_main);
      end
    end
    br_taken = 1'b0;
    cyc();
    cyc();
    n_cmp++;
    if (s_flush_cnt !== 2'd3 || s_dbg_state !== 2'd0) begin
      n_err++;
      $display("FAIL sat_hold: narrow=%0d st=%0d want 3/0", s_flush_cnt, s_dbg_state);
    end
  endtask

  task automatic test_reset_mid_flush();
    br_taken = 1'b1;
    cyc();
    br_taken = 1'b0;
    RSTN = 1'b0;
    #2;
    n_cmp++;
    if (outs !== O_RESET) begin
      n_err++;
      $display("FAIL rstflush_during: got %b want %b", outs, O_RESET);
    end
    cyc();
    RSTN = 1'b1;
    #2;
    n_cmp++;
    if (outs !== O_NORMAL || dbg_state !== 2'd0 || flush_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL rstflush_after: outs=%b st=%0d fc=%0d want %b/0/0", outs, dbg_state, flush_cnt, O_NORMAL);
    end
    cyc();
    #2;
    n_cmp++;
    if (outs !== O_NORMAL) begin
      n_err++;
      $display("FAIL rstflush_residual: got %b want %b", outs, O_NORMAL);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    RSTN  = 1'b0;
    idle_inputs();
    test_reset();
    test_branch();
    test_stall();
    test_hz_and_branch();
    test_back_to_back();
    test_saturation();
    test_reset_mid_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
